// File: rtl/sw_bounce_gen.sv
// Mechanical-switch emulator: turns a clean level command into a bouncy
// waveform (glitch burst, then a settled level) that drives a debouncer input.
module sw_bounce_gen #(
    parameter logic        INIT_LEVEL  = 1'b0,
    parameter int          FIX_BOUNCES = 2,
    parameter int          FIX_SEG     = 4,
    parameter int          NB_W        = 3,
    parameter int          SEG_W       = 5,
    parameter int          HOLD_CYC    = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk50m,
    input  logic rst,
    input  logic cmd_level,
    input  logic rand_en,
    output logic sw_out,
    output logic busy,
    output logic done
);

    localparam int SEG_CW = (SEG_W > $clog2(FIX_SEG)) ? SEG_W : $clog2(FIX_SEG);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int FLIP_W = NB_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                sw_q, sw_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                target_q, target_d;
    logic [FLIP_W-1:0]   flips_q, flips_d;
    logic [SEG_CW-1:0]   seg_q, seg_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         lfsr_q;

    logic [FLIP_W-1:0]   flips_init;
    logic [SEG_CW-1:0]   seg_reload;

    // Counters are loaded with length-1, so the random segment of
    // lfsr[SEG_W-1:0]+1 cycles reloads as the raw LFSR slice.
    assign flips_init = rand_en ? {lfsr_q[NB_W-1:0], 1'b0} : FLIP_W'(2 * FIX_BOUNCES);
    assign seg_reload = rand_en ? SEG_CW'(lfsr_q[SEG_W-1:0]) : SEG_CW'(FIX_SEG - 1);

    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        target_d = target_q;
        flips_d  = flips_q;
        seg_d    = seg_q;
        hold_d   = hold_q;

        case (state_q)
            IDLE: begin
                if (cmd_level != sw_q) begin
                    target_d = cmd_level;
                    sw_d     = cmd_level;
                    busy_d   = 1'b1;
                    flips_d  = flips_init;
                    seg_d    = seg_reload;
                    state_d  = BOUNCE;
                end
            end
            BOUNCE: begin
                if (seg_q != '0) begin
                    seg_d = seg_q - SEG_CW'(1);
                end else if (flips_q != '0) begin
                    sw_d    = ~sw_q;
                    flips_d = flips_q - FLIP_W'(1);
                    seg_d   = seg_reload;
                end else begin
                    // Even flip count: the level is already back at target here.
                    sw_d    = target_q;
                    hold_d  = HOLD_W'(HOLD_CYC - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                sw_d = target_q;
                if (hold_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_q  <= IDLE;
            sw_q     <= INIT_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= INIT_LEVEL;
            flips_q  <= '0;
            seg_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            target_q <= target_d;
            flips_q  <= flips_d;
            seg_q    <= seg_d;
            hold_q   <= hold_d;
        end
    end

    assign sw_out = sw_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Self-checking bench for sw_bounce_gen: each burst is predicted as a list of
// edge times derived from the bounce rules and compared cycle by cycle.
module tb_sw_bounce_gen;

    localparam int          FIX_BOUNCES = 2;
    localparam int          FIX_SEG     = 4;
    localparam int          NB_W        = 3;
    localparam int          SEG_W       = 5;
    localparam int          HOLD_CYC    = 8;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic clk50m = 1'b0;
    logic rst, cmd_level, rand_en, cmd_b;
    logic sw_out, busy, done;
    logic sw_b, busy_b, done_b;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] lfsr_ref;

    always #10 clk50m = ~clk50m;

    sw_bounce_gen #(
        .INIT_LEVEL(1'b0), .FIX_BOUNCES(FIX_BOUNCES), .FIX_SEG(FIX_SEG),
        .NB_W(NB_W), .SEG_W(SEG_W), .HOLD_CYC(HOLD_CYC), .LFSR_SEED(SEED)
    ) dut (
        .clk50m(clk50m), .rst(rst), .cmd_level(cmd_level), .rand_en(rand_en),
        .sw_out(sw_out), .busy(busy), .done(done)
    );

    sw_bounce_gen #(
        .INIT_LEVEL(1'b0), .FIX_BOUNCES(0), .FIX_SEG(FIX_SEG),
        .NB_W(NB_W), .SEG_W(SEG_W), .HOLD_CYC(HOLD_CYC), .LFSR_SEED(SEED)
    ) dut_nb0 (
        .clk50m(clk50m), .rst(rst), .cmd_level(cmd_b), .rand_en(1'b0),
        .sw_out(sw_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] m;
        m = v[0] ? 16'hB400 : 16'h0000;
        return {1'b0, v[15:1]} ^ m;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; lfsr_ref tracks the LFSR value seen at the next edge.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk50m);
        lfsr_ref = r ? SEED : lfsr_step(lfsr_ref);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle sw_out", sw_out, lvl);
            check("idle busy", busy, 1'b0);
            check("idle done", done, 1'b0);
        end
    endtask

    // Drives a command and checks the whole burst against a predicted edge list.
    task automatic do_burst(input logic lvl, input logic rnd, input int flip_at,
                            input int abort_at, output logic flipped);
        logic exp_sw[$];
        logic [15:0] lc;
        logic sw_m, prev;
        int nb_m, seg_m, flips, next_edge, hold_start, done_off, toggles;

        cmd_level = lvl;
        rand_en   = rnd;
        flipped   = 1'b0;
        lc    = lfsr_ref;
        nb_m  = rnd ? int'(lc[NB_W-1:0]) : FIX_BOUNCES;
        seg_m = rnd ? int'(lc[SEG_W-1:0]) + 1 : FIX_SEG;
        sw_m  = lvl;
        exp_sw.push_back(sw_m);
        flips      = 2 * nb_m;
        next_edge  = seg_m;
        hold_start = 0;
        for (int o = 1; o < 4000; o++) begin
            lc = lfsr_step(lc);
            if (o == next_edge) begin
                if (flips == 0) begin
                    hold_start = o;
                    break;
                end
                sw_m = ~sw_m;
                flips--;
                seg_m     = rnd ? int'(lc[SEG_W-1:0]) + 1 : FIX_SEG;
                next_edge = o + seg_m;
            end
            exp_sw.push_back(sw_m);
        end
        done_off = hold_start + HOLD_CYC;
        for (int o = hold_start; o <= done_off; o++) exp_sw.push_back(lvl);

        prev    = sw_out;
        toggles = 0;
        for (int o = 0; o <= done_off; o++) begin
            if (o == flip_at) begin
                cmd_level = ~lvl;
                flipped   = 1'b1;
            end
            if (o == abort_at) rst = 1'b1;
            tick();
            if (o == abort_at) begin
                check("abort sw_out", sw_out, 1'b0);
                check("abort busy", busy, 1'b0);
                check("abort done", done, 1'b0);
                return;
            end
            if (sw_out !== prev) toggles++;
            prev = sw_out;
            check($sformatf("sw_out @k+%0d", o), sw_out, exp_sw[o]);
            check($sformatf("busy @k+%0d", o), busy, (o < done_off));
            check($sformatf("done @k+%0d", o), done, (o == done_off));
        end
        check_int("transitions per burst", toggles, 2 * nb_m + 1);
    endtask

    initial begin
        logic fl, pending, cur;

        // Reset and idle
        rst = 1'b1; cmd_level = 1'b0; rand_en = 1'b0; cmd_b = 1'b0;
        repeat (3) tick();
        check("reset sw_out", sw_out, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset nb0 sw_out", sw_b, 1'b0);
        rst = 1'b0;
        idle_cycles(50, 1'b0);

        // Zero bounces: one clean edge, one segment dwell, then HOLD
        cmd_b = 1'b1;
        for (int o = 0; o <= FIX_SEG + HOLD_CYC + 1; o++) begin
            tick();
            check($sformatf("nb0 sw_out @k+%0d", o), sw_b, 1'b1);
            check($sformatf("nb0 busy @k+%0d", o), busy_b, (o < FIX_SEG + HOLD_CYC));
            check($sformatf("nb0 done @k+%0d", o), done_b, (o == FIX_SEG + HOLD_CYC));
        end

        // Deterministic rise and fall
        do_burst(1'b1, 1'b0, -1, -1, fl);
        idle_cycles(5, 1'b1);
        do_burst(1'b0, 1'b0, -1, -1, fl);
        idle_cycles(5, 1'b0);

        // Command change mid-burst is ignored, then serviced right after done
        do_burst(1'b1, 1'b0, 6, -1, fl);
        do_burst(1'b0, 1'b0, -1, -1, fl);
        idle_cycles(5, 1'b0);

        // Reset mid-burst
        do_burst(1'b1, 1'b0, -1, 9, fl);
        tick();
        check("in reset sw_out", sw_out, 1'b0);
        check("in reset busy", busy, 1'b0);
        cmd_level = 1'b0;
        rst = 1'b0;
        idle_cycles(20, 1'b0);
        do_burst(1'b1, 1'b0, -1, -1, fl);
        idle_cycles(3, 1'b1);

        // Random mode, with occasional ignored mid-burst command changes
        cur = 1'b1;
        pending = 1'b0;
        for (int i = 0; i < 200; i++) begin
            int flip_at;
            if (!pending) idle_cycles($urandom_range(0, 3), cur);
            flip_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            cur = ~cur;
            do_burst(cur, 1'b1, flip_at, -1, pending);
        end
        if (pending) do_burst(~cur, 1'b1, -1, -1, fl);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
